seq_barrel_shifter: RTL and testbench
=====================================

# seq_barrel_shifter

Multi-cycle 32-bit shift unit for the processor ALU path. Each cycle applies one power-of-two shift stage (16, 8, 4, 2, 1), so a single stage's worth of fixed-shift logic is reused across the cycles. It supports logical left, arithmetic right, logical right and rotate left. It uses a start/ready handshake and a fixed 5-cycle latency, which lets the pipeline stall on shifts without a full combinational barrel in the critical path.

## Interface
- No parameters; width fixed at 32, shift amount 5 bits.
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- ctrl_shift  input  1  start pulse; sampled on the rising edge.
- op  input  2  operation: 00 SLL, 01 SRA, 10 SRL, 11 ROL.
- data_in  input  32  operand.
- shamt  input  5  shift amount, 0–31.
- data_result  output  32  shifted result; holds until the next accepted start.
- data_resultRDY  output  1  one-cycle pulse, asserted while data_result is valid and new.
- bits_lost  output  1  SLL only: a 1 bit was shifted out of bit 31; 0 for other ops.
- busy  output  1  high while in state SHIFT.

## Operation
- States: IDLE, SHIFT, DONE. Stage counter cnt[2:0] runs 0–4 and selects stage size 16 >> cnt, gated by shamt[4 - cnt].
- IDLE or DONE, with ctrl_shift = 1 at an edge:
  - Latch data_in into the working register, and latch op and shamt.
  - Set cnt = 0 and enter SHIFT.
  - Clear bits_lost.
- Start accepted in DONE: data_resultRDY for the prior op still pulses in that cycle (back-to-back issue allowed).
- SHIFT, each edge:
  - If the selected shamt bit is 1, shift the working register by the stage size. Otherwise hold it.
  - Fill rules:
    - SLL and SRL fill with zeros.
    - SRA fills with the working register's bit 31.
    - ROL feeds the upper bits back into the low bits.
  - For SLL, OR any 1s shifted out into bits_lost.
  - Increment cnt. The edge that applies cnt = 4 moves to DONE, copies the working value to data_result and asserts data_resultRDY.
- DONE with no start: next edge returns to IDLE and deasserts data_resultRDY. data_result is held.
- ctrl_shift during SHIFT is ignored. There is no queueing, and the latched op, shamt and operand are unaffected.
- shamt = 0: all stages hold, result = operand, latency unchanged.
- op and shamt are read only at the accepting edge. Later changes have no effect.
- Reset (any time, including mid-SHIFT):
  - State → IDLE, cnt = 0, working register = 0.
  - data_result = 0, data_resultRDY = 0, bits_lost = 0, busy = 0.
  - The in-flight op is discarded.

## Timing
- Start accepted at edge E0. busy is high from after E0 until E5.
- Stage edges: E1 applies 16, E2 applies 8, E3 applies 4, E4 applies 2, E5 applies 1.
- After E5: data_result is valid, data_resultRDY = 1 and bits_lost is final. Latency is 5 cycles, fixed.
- data_resultRDY deasserts at E6, unless a new start at E5's DONE cycle keeps the unit busy, in which case it still deasserts at E6.
- Maximum throughput: one operation per 5 cycles (start presented in the DONE cycle).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- SLL, data_in = 0x0000000F, shamt = 4, start at E0:
  - data_result = 0x000000F0, RDY high only between E5 and E6.
  - busy high for exactly 5 cycles; bits_lost = 0.
- SRA 0x80000000 by 31 → 0xFFFFFFFF. SRA 0x7FFFFFFF by 31 → 0x00000000.
- SRL 0x80000000 by 31 → 0x00000001. ROL 0x80000001 by 4 → 0x00000018.
- SLL 0xF0000000 by 1 → 0xE0000000 with bits_lost = 1.
- Any op with shamt = 0 on 0xDEADBEEF → 0xDEADBEEF, RDY still at E5.
- Mid-operation start and back-to-back issue:
  - ctrl_shift pulsed with new operands at E2 → ignored; the original result is unchanged at E5.
  - Start at E5 (DONE) → second result at E10.
- reset asserted asynchronously between E2 and E3:
  - All outputs are 0 immediately, with no RDY pulse.
  - After release, SLL 0x1 by 31 → 0x80000000 with normal 5-cycle latency.

Source files
------------

// File: rtl/seq_barrel_shifter.sv
// Multi-cycle 32-bit shifter: one power-of-two stage per cycle
// (16, 8, 4, 2, 1), start/ready handshake, fixed 5-cycle latency.
module seq_barrel_shifter (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_shift,
  input  logic [1:0]  op,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        bits_lost,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [31:0] work;
  logic [31:0] work_nxt;
  logic [1:0]  op_q;
  logic [4:0]  shamt_q;
  logic [4:0]  stage;
  logic        apply;
  logic        lost;
  logic        start;
  logic [63:0] wide;

  assign start = ctrl_shift && (state != SHIFT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == 3'd4) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage size and the shamt bit that gates it, MSB first.
  always_comb begin
    stage = 5'd0;
    apply = 1'b0;
    unique case (cnt)
      3'd0:    begin stage = 5'd16; apply = shamt_q[4]; end
      3'd1:    begin stage = 5'd8;  apply = shamt_q[3]; end
      3'd2:    begin stage = 5'd4;  apply = shamt_q[2]; end
      3'd3:    begin stage = 5'd2;  apply = shamt_q[1]; end
      3'd4:    begin stage = 5'd1;  apply = shamt_q[0]; end
      default: begin stage = 5'd0;  apply = 1'b0;       end
    endcase
  end

  // Widen to 64 bits so fill and spill fall out of one shift.
  always_comb begin
    wide     = 64'd0;
    work_nxt = work;
    lost     = 1'b0;
    if (apply) begin
      unique case (op_q)
        OP_SLL: begin
          wide     = {32'd0, work} << stage;
          work_nxt = wide[31:0];
          lost     = |wide[63:32];
        end
        OP_SRA: begin
          wide     = {{32{work[31]}}, work} >> stage;
          work_nxt = wide[31:0];
        end
        OP_SRL: begin
          wide     = {32'd0, work} >> stage;
          work_nxt = wide[31:0];
        end
        OP_ROL: begin
          wide     = {work, work} << stage;
          work_nxt = wide[63:32];
        end
        default: work_nxt = work;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt            <= 3'd0;
      work           <= 32'd0;
      op_q           <= 2'd0;
      shamt_q        <= 5'd0;
      data_result    <= 32'd0;
      data_resultRDY <= 1'b0;
      bits_lost      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      busy           <= (state_nxt == SHIFT);
      data_resultRDY <= (state == SHIFT) && (cnt == 3'd4);
      if (start) begin
        work      <= data_in;
        op_q      <= op;
        shamt_q   <= shamt;
        cnt       <= 3'd0;
        bits_lost <= 1'b0;
      end else if (state == SHIFT) begin
        work <= work_nxt;
        cnt  <= cnt + 3'd1;
        if (op_q == OP_SLL) bits_lost <= bits_lost | lost;
        if (cnt == 3'd4) data_result <= work_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Directed bench for seq_barrel_shifter: vector table plus
// hand-written mid-op, back-to-back and async-reset sequences.
module tb_seq_barrel_shifter;

  logic        clock;
  logic        reset;
  logic        ctrl_shift;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        bits_lost;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] din;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        lost;
  } vec_t;

  vec_t vecs[16];
  vec_t v;

  seq_barrel_shifter dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_shift     (ctrl_shift),
    .op             (op),
    .data_in        (data_in),
    .shamt          (shamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .bits_lost      (bits_lost),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] br(input logic b, input logic r);
    return {30'd0, b, r};
  endfunction

  // Start at E0, then check busy/RDY every cycle through E6.
  task automatic run_op(input vec_t t, input string tag);
    op         = t.op;
    data_in    = t.din;
    shamt      = t.sh;
    ctrl_shift = 1'b1;
    tick();
    ctrl_shift = 1'b0;
    op         = ~t.op;
    data_in    = ~t.din;
    shamt      = ~t.sh;
    for (int k = 0; k < 5; k++) begin
      chk({tag, " busy/rdy in shift"}, br(busy, data_resultRDY), br(1'b1, 1'b0));
      tick();
    end
    chk({tag, " busy/rdy at E5"}, br(busy, data_resultRDY), br(1'b0, 1'b1));
    chk({tag, " result"}, data_result, t.res);
    chk({tag, " bits_lost"}, {31'd0, bits_lost}, {31'd0, t.lost});
    tick();
    chk({tag, " busy/rdy at E6"}, br(busy, data_resultRDY), br(1'b0, 1'b0));
    chk({tag, " result held"}, data_result, t.res);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'h0000000F, 5'd4,  32'h000000F0, 1'b0};
    vecs[1]  = '{2'b01, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{2'b01, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b0};
    vecs[3]  = '{2'b10, 32'h80000000, 5'd31, 32'h00000001, 1'b0};
    vecs[4]  = '{2'b11, 32'h80000001, 5'd4,  32'h00000018, 1'b0};
    vecs[5]  = '{2'b00, 32'hF0000000, 5'd1,  32'hE0000000, 1'b1};
    vecs[6]  = '{2'b00, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0};
    vecs[7]  = '{2'b01, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0};
    vecs[8]  = '{2'b10, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0};
    vecs[9]  = '{2'b11, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0};
    vecs[10] = '{2'b01, 32'h80000000, 5'd4,  32'hF8000000, 1'b0};
    vecs[11] = '{2'b11, 32'h12345678, 5'd8,  32'h34567812, 1'b0};
    vecs[12] = '{2'b10, 32'hF0000000, 5'd5,  32'h07800000, 1'b0};
    vecs[13] = '{2'b00, 32'h00000003, 5'd31, 32'h80000000, 1'b1};
    vecs[14] = '{2'b11, 32'hA5000000, 5'd31, 32'h52800000, 1'b0};
    vecs[15] = '{2'b00, 32'h00010000, 5'd16, 32'h00000000, 1'b1};

    reset      = 1'b1;
    ctrl_shift = 1'b0;
    op         = 2'b00;
    data_in    = 32'd0;
    shamt      = 5'd0;
    #12;
    chk("reset result", data_result, 32'd0);
    chk("reset busy/rdy", br(busy, data_resultRDY), br(1'b0, 1'b0));
    chk("reset bits_lost", {31'd0, bits_lost}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      run_op(v, $sformatf("vec%0d", i));
    end

    // Mid-op start ignored, then back-to-back issue from DONE.
    op         = 2'b00;
    data_in    = 32'h0000000F;
    shamt      = 5'd4;
    ctrl_shift = 1'b1;
    tick();
    ctrl_shift = 1'b0;
    tick();
    tick();
    op         = 2'b11;
    data_in    = 32'hFFFF0000;
    shamt      = 5'd7;
    ctrl_shift = 1'b1;
    tick();
    ctrl_shift = 1'b0;
    chk("midop busy", {31'd0, busy}, 32'd1);
    tick();
    tick();
    chk("midop rdy", br(busy, data_resultRDY), br(1'b0, 1'b1));
    chk("midop result", data_result, 32'h000000F0);
    op         = 2'b10;
    data_in    = 32'h00000100;
    shamt      = 5'd8;
    ctrl_shift = 1'b1;
    tick();
    ctrl_shift = 1'b0;
    chk("b2b accept busy/rdy", br(busy, data_resultRDY), br(1'b1, 1'b0));
    for (int k = 0; k < 4; k++) tick();
    chk("b2b pre busy/rdy", br(busy, data_resultRDY), br(1'b1, 1'b0));
    tick();
    chk("b2b busy/rdy", br(busy, data_resultRDY), br(1'b0, 1'b1));
    chk("b2b result", data_result, 32'h00000001);
    tick();

    // Async reset between E2 and E3 of an in-flight op.
    op         = 2'b00;
    data_in    = 32'hFFFFFFFF;
    shamt      = 5'd31;
    ctrl_shift = 1'b1;
    tick();
    ctrl_shift = 1'b0;
    tick();
    tick();
    chk("pre-reset bits_lost", {31'd0, bits_lost}, 32'd1);
    chk("pre-reset result", data_result, 32'h00000001);
    #3;
    reset = 1'b1;
    #1;
    chk("async reset result", data_result, 32'd0);
    chk("async reset busy/rdy", br(busy, data_resultRDY), br(1'b0, 1'b0));
    chk("async reset bits_lost", {31'd0, bits_lost}, 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("post-reset no rdy", br(busy, data_resultRDY), br(1'b0, 1'b0));
      tick();
    end
    v = '{2'b00, 32'h00000001, 5'd31, 32'h80000000, 1'b0};
    run_op(v, "after reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
